// File: rtl/joy_serial_scan.sv
// ---------------------------------------------------------------------------
// joy_serial_scan
//   Scans a daisy-chained parallel-in/serial-out controller shift register
//   (one chain for NUM_PLAYERS pads). Each frame pulses joy_load low for one
//   tick, then clocks out NUM_PLAYERS*BITS_PER_PLAYER bits with joy_clk and
//   waits GAP_TICKS idle ticks. Completed frames pass through a debounce
//   filter before they reach the joystick outputs.
//
// Ports
//   clk_sys_i     in   system clock, rising edge
//   reset_i       in   asynchronous active-high reset
//   enable_i      in   scan enable; low parks the bus (clk/load high)
//   joy_data_i    in   serial data from the chain (already synchronised)
//   joy_clk_o     out  shift clock to the chain (registered)
//   joy_load_o    out  parallel-load strobe, active low (registered)
//   joystick_o    out  debounced pad state, player p at [16p+15:16p]
//   frame_done_o  out  one-cycle pulse when a full shift phase completes
//
// States
//   state      | meaning
//   -----------+--------------------------------------------------------
//   S_IDLE     | bus parked high, waiting for enable on a tick
//   S_LOAD     | joy_load low for one tick period
//   S_SHIFT_LO | joy_clk low; data sampled on the closing tick
//   S_SHIFT_HI | joy_clk high; bit counter advances on the closing tick
//   S_GAP      | bus idle high for GAP_TICKS ticks between frames
// ---------------------------------------------------------------------------
module joy_serial_scan #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV         = 40,
  parameter int GAP_TICKS       = 16,
  parameter int DEBOUNCE        = 2,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                      clk_sys_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      joy_data_i,
  output logic                      joy_clk_o,
  output logic                      joy_load_o,
  output logic [NUM_PLAYERS*16-1:0] joystick_o,
  output logic                      frame_done_o
);

  localparam int              PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int              JW        = NUM_PLAYERS * 16;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [1:0]      LAST_PL   = 2'(NUM_PLAYERS - 1);
  localparam logic [3:0]      LAST_PB   = 4'(BITS_PER_PLAYER - 1);
  localparam logic [7:0]      GAP_LOAD  = (GAP_TICKS > 0) ? 8'(GAP_TICKS - 1) : 8'd0;
  localparam logic [2:0]      DB_MAX    = 3'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      pl_q, pl_d;        // player index of the current bit
  logic [3:0]      pb_q, pb_d;        // bit index within that player
  logic [7:0]      gap_q, gap_d;
  logic [JW-1:0]   cur_q, cur_d;      // frame being assembled
  logic [JW-1:0]   prev_q, prev_d;    // last completed raw frame
  logic [2:0]      stab_q, stab_d;
  logic [JW-1:0]   joystick_q, joystick_d;
  logic            frame_done_q, frame_done_d;
  logic            joy_clk_q, joy_clk_d;
  logic            joy_load_q, joy_load_d;

  logic            tick;
  logic            last_bit;
  logic            sample;
  logic            frame_end;
  logic            sample_bit;

  assign tick       = (presc_q == PRESC_MAX);
  assign last_bit   = (pl_q == LAST_PL) && (pb_q == LAST_PB);
  assign sample_bit = (ACTIVE_LOW != 0) ? ~joy_data_i : joy_data_i;

  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Sequencer: every transition is gated by tick so the bus changes only on
  // prescaler boundaries. Dropping enable aborts from any state.
  always_comb begin
    state_d   = state_q;
    pl_d      = pl_q;
    pb_d      = pb_q;
    gap_d     = gap_q;
    sample    = 1'b0;
    frame_end = 1'b0;

    if (tick) begin
      if (!enable_i) begin
        state_d = S_IDLE;
        pl_d    = 2'd0;
        pb_d    = 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_d = S_LOAD;
          end
          S_LOAD: begin
            state_d = S_SHIFT_LO;
            pl_d    = 2'd0;
            pb_d    = 4'd0;
          end
          S_SHIFT_LO: begin
            sample  = 1'b1;
            state_d = S_SHIFT_HI;
          end
          S_SHIFT_HI: begin
            if (last_bit) begin
              frame_end = 1'b1;
              pl_d      = 2'd0;
              pb_d      = 4'd0;
              if (GAP_TICKS == 0) begin
                state_d = S_LOAD;
              end else begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
              end
            end else begin
              state_d = S_SHIFT_LO;
              if (pb_q == LAST_PB) begin
                pb_d = 4'd0;
                pl_d = pl_q + 2'd1;
              end else begin
                pb_d = pb_q + 4'd1;
              end
            end
          end
          S_GAP: begin
            if (gap_q == 8'd0) begin
              state_d = S_LOAD;
            end else begin
              gap_d = gap_q - 8'd1;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  // Bits land directly in their player slot so unused upper bits of each
  // 16-bit lane are never written and stay zero.
  always_comb begin
    cur_d = cur_q;
    if (sample) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        for (int b = 0; b < BITS_PER_PLAYER; b++) begin
          if (pl_q == 2'(p) && pb_q == 4'(b)) begin
            cur_d[p*16+b] = sample_bit;
          end
        end
      end
    end
  end

  // Debounce: stab counts consecutive identical completed frames. The output
  // update happens one cycle after frame_done, once stab_q reflects the frame.
  always_comb begin
    prev_d     = prev_q;
    stab_d     = stab_q;
    joystick_d = joystick_q;

    if (frame_end) begin
      prev_d = cur_q;
      if (cur_q == prev_q) begin
        stab_d = (stab_q == DB_MAX) ? stab_q : stab_q + 3'd1;
      end else begin
        stab_d = 3'd1;
      end
    end

    if (frame_done_q && (stab_q == DB_MAX)) begin
      joystick_d = prev_q;
    end
  end

  // Bus outputs derive from the next state and are registered, so they
  // change only on the tick edge and load/clk can never be low together.
  assign frame_done_d = frame_end;
  assign joy_clk_d    = (state_d != S_SHIFT_LO);
  assign joy_load_d   = (state_d != S_LOAD);

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      pl_q         <= 2'd0;
      pb_q         <= 4'd0;
      gap_q        <= 8'd0;
      cur_q        <= '0;
      prev_q       <= '0;
      stab_q       <= 3'd0;
      joystick_q   <= '0;
      frame_done_q <= 1'b0;
      joy_clk_q    <= 1'b1;
      joy_load_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      pl_q         <= pl_d;
      pb_q         <= pb_d;
      gap_q        <= gap_d;
      cur_q        <= cur_d;
      prev_q       <= prev_d;
      stab_q       <= stab_d;
      joystick_q   <= joystick_d;
      frame_done_q <= frame_done_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
    end
  end

  assign joy_clk_o    = joy_clk_q;
  assign joy_load_o   = joy_load_q;
  assign joystick_o   = joystick_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_joy_serial_scan.sv
module tb_joy_serial_scan;

  localparam int NP    = 2;
  localparam int BPP   = 12;
  localparam int DIV   = 4;
  localparam int GAP   = 2;
  localparam int DEB   = 2;
  localparam int PERIOD_CLK  = (1 + 2*NP*BPP + GAP) * DIV;   // 204
  localparam int PERIOD0_CLK = (1 + 2*NP*BPP) * DIV;         // 196

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        enable;
  logic        joy_data;
  logic        joy_clk, joy_load, frame_done;
  logic [31:0] joystick;
  logic        joy_clk0, joy_load0, frame_done0;
  logic [31:0] joystick0;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  joy_serial_scan #(
    .NUM_PLAYERS(NP), .BITS_PER_PLAYER(BPP), .CLK_DIV(DIV),
    .GAP_TICKS(GAP), .DEBOUNCE(DEB), .ACTIVE_LOW(1)
  ) dut (
    .clk_sys_i(clk_sys), .reset_i(reset), .enable_i(enable),
    .joy_data_i(joy_data), .joy_clk_o(joy_clk), .joy_load_o(joy_load),
    .joystick_o(joystick), .frame_done_o(frame_done)
  );

  // Second build with no gap between frames.
  joy_serial_scan #(
    .NUM_PLAYERS(NP), .BITS_PER_PLAYER(BPP), .CLK_DIV(DIV),
    .GAP_TICKS(0), .DEBOUNCE(DEB), .ACTIVE_LOW(1)
  ) dut0 (
    .clk_sys_i(clk_sys), .reset_i(reset), .enable_i(enable),
    .joy_data_i(1'b1), .joy_clk_o(joy_clk0), .joy_load_o(joy_load0),
    .joystick_o(joystick0), .frame_done_o(frame_done0)
  );

  // Controller chain: latches pad state while load is low, shifts on each
  // rising joy_clk, drives pressed buttons as 0 on the wire.
  logic [11:0] nxt0 = '0, nxt1 = '0, lat0 = '0, lat1 = '0;
  logic [5:0]  ptr = '0;
  logic [23:0] latv;
  assign latv = {lat1, lat0};

  always @(negedge joy_load) begin
    lat0 = nxt0;
    lat1 = nxt1;
    ptr  = 6'd0;
  end

  always @(posedge joy_clk) ptr = ptr + 6'd1;

  always_comb joy_data = (ptr < 6'd24) ? ~latv[ptr[4:0]] : 1'b1;

  // Reference: joystick shows a frame once the last DEB completed frames
  // since reset are all identical.
  logic [23:0] hist[$];
  logic [31:0] exp_js = '0;

  task automatic model_push(input logic [23:0] f);
    bit same;
    hist.push_back(f);
    if (hist.size() >= DEB) begin
      same = 1'b1;
      for (int i = 1; i < DEB; i++)
        if (hist[hist.size()-1-i] != f) same = 1'b0;
      if (same) exp_js = {4'b0, f[23:12], 4'b0, f[11:0]};
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 1000);
  endtask

  // Called at a frame_done sample: record the finished frame, queue the next
  // pad pattern, check the debounced output and the next frame period.
  task automatic frame_step(input logic [11:0] n0, input logic [11:0] n1);
    int n;
    model_push({lat1, lat0});
    nxt0 = n0;
    nxt1 = n1;
    step();
    chk("joystick_model", joystick, exp_js);
    wait_fd(n);
    chk("frame_period", n + 1, PERIOD_CLK);
  endtask

  initial begin
    int n, pulses, badw, both, w, viol, fdc;
    logic pc, seen0;
    logic [31:0] js_hold;

    reset = 1'b1;
    enable = 1'b0;
    nxt0 = 12'h005;
    nxt1 = 12'hA3C;
    repeat (3) step();
    chk("rst_joy_clk", joy_clk, 1'b1);
    chk("rst_joy_load", joy_load, 1'b1);
    chk("rst_joystick", joystick, 32'h0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_gap0_clk_load", {joy_clk0, joy_load0}, 2'b11);

    // Release with enable high: first LOAD on the first tick.
    enable = 1'b1;
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (joy_load !== 1'b0 && n < 20);
    chk("first_load_delay", n, DIV);
    n = 0;
    while (joy_load === 1'b0 && n < 20) begin n++; step(); end
    chk("load_width", n, DIV);

    pulses = 0; badw = 0; both = 0; w = 0; pc = 1'b1; n = 0;
    while (frame_done !== 1'b1 && n < 400) begin
      if (joy_clk === 1'b0) begin
        if (pc) begin pulses++; w = 0; end
        w++;
      end else if (!pc && w != DIV) begin
        badw++;
      end
      if (joy_clk === 1'b0 && joy_load === 1'b0) both++;
      pc = joy_clk;
      step();
      n++;
    end
    chk("fd1_seen", frame_done, 1'b1);
    chk("clk_pulse_count", pulses, NP*BPP);
    chk("clk_pulse_width_bad", badw, 0);
    chk("clk_load_both_low", both, 0);
    chk("gap_load_high", joy_load, 1'b1);
    chk("js_at_fd1", joystick, 32'h0);

    frame_step(12'h005, 12'hA3C);
    chk("js_after_one_frame", joystick, 32'h0);
    frame_step(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    chk("js_after_two_frames", joystick, 32'h0A3C_0005);

    // Random frames, roughly half repeating the previous pattern.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0)
        frame_step(nxt0, nxt1);
      else
        frame_step(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    end

    // Alternating player-0 frames never become stable.
    frame_step(12'h001, 12'h000);
    frame_step(12'h002, 12'h000);
    js_hold = joystick;
    frame_step(12'h001, 12'h000);
    chk("alt_hold_1", joystick, js_hold);
    frame_step(12'h002, 12'h000);
    chk("alt_hold_2", joystick, js_hold);
    frame_step(12'h001, 12'h000);
    chk("alt_hold_3", joystick, js_hold);

    // Drop enable while bit 10 is being shifted.
    model_push({lat1, lat0});
    nxt0 = 12'h3C3;
    nxt1 = 12'h0F0;
    pulses = 0; pc = joy_clk; n = 0;
    while (pulses < 11 && n < 400) begin
      step();
      n++;
      if (joy_clk === 1'b0 && pc === 1'b1) pulses++;
      pc = joy_clk;
    end
    chk("abort_reached_bit10", pulses, 11);
    enable = 1'b0;
    viol = 0; fdc = 0;
    for (int i = 0; i < 44; i++) begin
      step();
      if (frame_done === 1'b1) fdc++;
      if (i >= 4 && (joy_clk !== 1'b1 || joy_load !== 1'b1)) viol++;
    end
    chk("abort_no_frame_done", fdc, 0);
    chk("abort_bus_idle", viol, 0);
    chk("abort_js_hold", joystick, exp_js);
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (joy_load !== 1'b0 && n < 20);
    chk("reenable_load_within_div", (n >= 1 && n <= DIV), 1'b1);
    wait_fd(n);
    chk("fd_after_reenable", frame_done, 1'b1);
    frame_step(12'h123, 12'h456);
    frame_step(12'h123, 12'h456);
    frame_step(12'h123, 12'h456);

    // Reset pulsed during SHIFT_HI acts without waiting for a clock edge.
    seen0 = 1'b0; n = 0;
    while (!(seen0 && joy_clk === 1'b1) && n < 400) begin
      step();
      n++;
      if (joy_clk === 1'b0) seen0 = 1'b1;
    end
    chk("js_pre_reset", joystick, exp_js);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_joy_clk", joy_clk, 1'b1);
    chk("async_rst_joy_load", joy_load, 1'b1);
    chk("async_rst_joystick", joystick, 32'h0);
    chk("async_rst_frame_done", frame_done, 1'b0);
    hist.delete();
    exp_js = '0;
    step();
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (joy_load !== 1'b0 && n < 20);
    chk("post_reset_load_delay", n, DIV);
    wait_fd(n);
    chk("post_reset_first_frame", n, PERIOD0_CLK);
    frame_step(12'h123, 12'h456);
    frame_step(12'h123, 12'h456);
    chk("post_reset_js", joystick, 32'h0456_0123);

    // Zero-gap build: LOAD immediately follows the last shift.
    n = 0;
    do begin step(); n++; end while (frame_done0 !== 1'b1 && n < 400);
    chk("gap0_fd_seen", frame_done0, 1'b1);
    chk("gap0_load_follows", joy_load0, 1'b0);
    n = 0;
    do begin step(); n++; end while (frame_done0 !== 1'b1 && n < 400);
    chk("gap0_period", n, PERIOD0_CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
